i2c_byte_writer: RTL and testbench
==================================

# i2c_byte_writer

Single-byte I2C write master clocked by the system clock: on request it issues START, an 8-bit slave address, one 8-bit data byte and STOP on an open-drain SCL/SDA pair, checking the slave ACK after each byte. It is the initiator for our single-byte PWM slave receiver, which matches a full 8-bit address with no R/W bit and latches one data byte. It sits between host control logic and the board-level I2C pads.

## Interface
- CLK_DIV, 250, system clocks per quarter SCL period; minimum 4; SCL period = 4*CLK_DIV clocks.
- CLK  input  1  system clock; all logic on rising edge.
- RST_N  input  1  synchronous, active-low reset.
- START  input  1  request; sampled each cycle, accepted only when BUSY=0.
- ADDR  input  8  slave address, sent MSB first; captured on accept.
- DATA  input  8  data byte, sent MSB first; captured on accept.
- SDA_IN  input  1  bus SDA level from the pad; passes through an internal 2-flop synchronizer.
- SCL_OE  output  1  1 = pull SCL low, 0 = release. Pad logic is `SCL = SCL_OE ? 0 : z`.
- SDA_OE  output  1  1 = pull SDA low, 0 = release.
- BUSY  output  1  transaction in progress.
- DONE  output  1  one-cycle pulse at transaction end.
- ACK_ERR  output  1  last transaction got a NACK. Held until the next accepted START.

## Operation
- Reset (RST_N=0 at a rising edge): SCL_OE=0, SDA_OE=0, BUSY=0, DONE=0, ACK_ERR=0, state IDLE, divider=0, synchronizer flops=1.
- Quarter tick: the divider counts 0..CLK_DIV-1 and ticks on wrap. It is held at 0 in IDLE and restarts at 0 on accept.
- States: IDLE -> START_C -> ADDR -> ACK_A -> DATA -> ACK_D -> STOP_C -> IDLE.
- IDLE: both lines released. START=1 with BUSY=0 does the following on that edge:
  - latch ADDR and DATA;
  - BUSY=1, ACK_ERR=0;
  - enter START_C.
- START_C (2 quarters): SCL released throughout.
  - Q0: SDA_OE=1.
  - Q1: SDA_OE=1 held.
  - Exit to ADDR.
- Bit slot (4 quarters), used for each of the 8 bits in ADDR and in DATA:
  - Q0: SCL_OE=1; SDA_OE = ~bit, updated on Q0 entry.
  - Q1 and Q2: SCL released.
  - Q3: SCL_OE=1.
  - SDA is changed only on Q0 entry, i.e. only while SCL is low.
  - An internal bit counter runs 7..0; after bit 0 the block moves to the ACK slot.
- ACK_A / ACK_D: one bit slot with SDA_OE=0 throughout.
  - The synchronized SDA_IN is sampled in the last cycle of Q2: 0 = ACK, 1 = NACK.
  - ACK_A with ACK: go to DATA.
  - ACK_A with NACK: set ACK_ERR=1 and go to STOP_C. DATA is never driven.
  - ACK_D with NACK: set ACK_ERR=1. Always go to STOP_C.
- STOP_C (4 quarters):
  - Q0: SCL_OE=1, SDA_OE=1.
  - Q1: SCL released, SDA_OE=1.
  - Q2: SDA released (STOP edge while SCL high).
  - Q3: both lines released (bus-free time).
- End of transaction: after STOP_C Q3 ends, return to IDLE with BUSY=0 and DONE=1 for one cycle.
- No clock stretching; SCL is never read back. No arbitration or multi-master support.

## Timing
- Latency: START sampled at edge k gives SDA_OE=1 and BUSY=1 from edge k+1.
- DONE width: exactly one cycle.
- DONE position, counted from edge k+1:
  - full transaction (78 quarters): DONE at edge k+1+78*CLK_DIV;
  - address NACK (42 quarters): DONE at edge k+1+42*CLK_DIV.
- BUSY falls on the same edge that DONE rises. ACK_ERR is valid from that edge.
- START asserted in the DONE cycle is accepted, giving back-to-back transactions separated only by STOP_C Q3.
- START while BUSY=1 is ignored: no queueing, and latched ADDR/DATA are unchanged.
- ACK sample point: the SDA_IN to decision delay is 2 sync cycles. CLK_DIV>=4 keeps the sample inside SCL high, at least 1 quarter after the SCL rise.
- Reset mid-transaction: both lines are released at the next edge. This can produce a spurious STOP or START on the bus. BUSY=0 and no DONE pulse is issued.

## Test plan
- Reset: hold RST_N=0 for 3 cycles with START=1 -> all outputs 0, no transaction starts. Release RST_N with START=0 -> lines stay released.
- Nominal write, CLK_DIV=4, bench slave model at address 8'hAB always ACKing:
  - stimulus: ADDR=8'hAB, DATA=8'h5A;
  - required: decoded bus shows START, 8'hAB, ACK, 8'h5A, ACK, STOP;
  - required: DONE exactly 312 cycles after the first SDA_OE=1, ACK_ERR=0, slave output=8'h5A;
  - required: SDA never changes while SCL is high, except at START and STOP.
- Address NACK, CLK_DIV=4, ADDR=8'h12 with no slave responding:
  - ACK_ERR=1;
  - DONE 168 cycles after start;
  - no SCL pulses between ACK_A and STOP_C.
- Data NACK: model ACKs the address and NACKs the data -> all 78 quarters run, ACK_ERR=1. A following good transaction clears ACK_ERR to 0 at its accept edge.
- Request handling, CLK_DIV=5:
  - START pulsed mid-ADDR with ADDR=8'hFF -> ignored, and the transmitted address is unchanged;
  - START asserted in the DONE cycle -> accepted, and a second transaction follows immediately.
- Reset during DATA bit 3 -> SCL_OE=0, SDA_OE=0, BUSY=0 on the next edge. The next START runs a full correct transaction.

Source files
------------

// File: rtl/i2c_byte_writer_if.sv
// Host/pad-side signal bundle of the single-byte I2C write master.
// The master modport is the writer itself; the slave modport is the side
// that drives the request and the pad SDA level and observes the results.
`timescale 1ns/1ps
interface i2c_byte_writer_if;
  logic       i_start;
  logic [7:0] i_addr;
  logic [7:0] i_data;
  logic       i_sda_in;
  logic       o_scl_oe;
  logic       o_sda_oe;
  logic       o_busy;
  logic       o_done;
  logic       o_ack_err;

  modport master (
    input  i_start, i_addr, i_data, i_sda_in,
    output o_scl_oe, o_sda_oe, o_busy, o_done, o_ack_err
  );

  modport slave (
    output i_start, i_addr, i_data, i_sda_in,
    input  o_scl_oe, o_sda_oe, o_busy, o_done, o_ack_err
  );
endinterface

// File: rtl/i2c_byte_writer.sv
// Single-byte I2C write master: START, 8-bit address, ACK, 8-bit data, ACK,
// STOP on open-drain SCL/SDA. All bus timing is built from quarter-SCL
// periods of CLK_DIV system clocks (CLK_DIV must be at least 4 so the ACK
// sample, delayed by the SDA synchronizer, stays inside SCL high).
`timescale 1ns/1ps
module i2c_byte_writer #(
  parameter int CLK_DIV = 250
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  i2c_byte_writer_if.master bus
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_C,
    S_ADDR,
    S_ACK_A,
    S_DATA,
    S_ACK_D,
    S_STOP_C
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_quarter;
  logic [2:0]       r_bit;
  logic [7:0]       r_addr;
  logic [7:0]       r_data;
  logic [1:0]       r_sda_sync;
  logic             r_nack;
  logic             r_scl_oe;
  logic             r_sda_oe;
  logic             r_busy;
  logic             r_done;
  logic             r_ack_err;

  logic             w_tick;
  logic             w_accept;
  logic [2:0]       w_next_bit;
  logic [7:0]       w_shift_byte;
  logic             w_next_sda;

  // Quarter boundary, request acceptance and the SDA level for the next bit slot.
  assign w_tick       = (r_div == DIV_LAST);
  assign w_accept     = (r_state == S_IDLE) && bus.i_start;
  assign w_next_bit   = r_bit - 3'd1;
  assign w_shift_byte = (r_state == S_DATA) ? r_data : r_addr;
  assign w_next_sda   = ~w_shift_byte[w_next_bit];

  // Two-flop synchronizer for the pad SDA level.
  // NOTE: flops reset to 1 (idle bus level) so a reset can never look like an ACK.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sda_sync <= 2'b11;
    end else begin
      r_sda_sync <= {r_sda_sync[0], bus.i_sda_in};
    end
  end

  // Capture the address and data byte when a request is accepted.
  // NOTE: pure datapath registers, only read after a capture, so they carry no reset.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_addr <= bus.i_addr;
      r_data <= bus.i_data;
    end
  end

  // Transaction sequencer: quarter timing, bit shifting and registered bus drive.
  // NOTE: every state register here is updated with <= so all of them see the
  // pre-edge values of each other, exactly like the flops they become.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_quarter <= 2'd0;
      r_bit     <= 3'd0;
      r_nack    <= 1'b0;
      r_scl_oe  <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        r_div <= '0;
        if (w_accept) begin
          r_state   <= S_START_C;
          r_quarter <= 2'd0;
          r_scl_oe  <= 1'b0;
          r_sda_oe  <= 1'b1;
          r_busy    <= 1'b1;
          r_ack_err <= 1'b0;
        end
      end else begin
        r_div <= w_tick ? '0 : r_div + DIV_W'(1);
        if (w_tick) begin
          r_quarter <= r_quarter + 2'd1;
          case (r_state)
            S_START_C: begin
              if (r_quarter == 2'd1) begin
                r_state   <= S_ADDR;
                r_quarter <= 2'd0;
                r_bit     <= 3'd7;
                r_scl_oe  <= 1'b1;
                r_sda_oe  <= ~r_addr[7];
              end
            end
            S_ADDR, S_DATA: begin
              case (r_quarter)
                2'd0: r_scl_oe <= 1'b0;
                2'd1: r_scl_oe <= 1'b0;
                2'd2: r_scl_oe <= 1'b1;
                default: begin
                  // SCL is already low; SDA may move now.
                  if (r_bit == 3'd0) begin
                    r_state  <= (r_state == S_ADDR) ? S_ACK_A : S_ACK_D;
                    r_sda_oe <= 1'b0;
                  end else begin
                    r_bit    <= w_next_bit;
                    r_sda_oe <= w_next_sda;
                  end
                end
              endcase
            end
            S_ACK_A, S_ACK_D: begin
              case (r_quarter)
                2'd0: r_scl_oe <= 1'b0;
                2'd1: r_scl_oe <= 1'b0;
                2'd2: begin
                  r_scl_oe <= 1'b1;
                  r_nack   <= r_sda_sync[1];
                end
                default: begin
                  if (r_nack) r_ack_err <= 1'b1;
                  if ((r_state == S_ACK_A) && !r_nack) begin
                    r_state  <= S_DATA;
                    r_bit    <= 3'd7;
                    r_sda_oe <= ~r_data[7];
                  end else begin
                    r_state  <= S_STOP_C;
                    r_sda_oe <= 1'b1;
                  end
                end
              endcase
            end
            S_STOP_C: begin
              case (r_quarter)
                2'd0: r_scl_oe <= 1'b0;
                2'd1: r_sda_oe <= 1'b0;
                2'd2: r_scl_oe <= 1'b0;
                default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end
              endcase
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

  // Registered outputs straight to the pads and the host.
  assign bus.o_scl_oe  = r_scl_oe;
  assign bus.o_sda_oe  = r_sda_oe;
  assign bus.o_busy    = r_busy;
  assign bus.o_done    = r_done;
  assign bus.o_ack_err = r_ack_err;

endmodule

// File: tb/tb_i2c_byte_writer.sv
// Bench for i2c_byte_writer: two instances (CLK_DIV 4 and 5), a bus decoder
// with a single-byte slave model, and an event scoreboard.
`timescale 1ns/1ps
module tb_i2c_byte_writer;

  localparam int         DIV0     = 4;
  localparam int         DIV1     = 5;
  localparam logic [3:0] EV_START = 4'd1;
  localparam logic [3:0] EV_BYTE  = 4'd2;
  localparam logic [3:0] EV_STOP  = 4'd3;
  localparam logic [3:0] EV_DONE  = 4'd4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_n_r = 2'b00;
  logic [1:0] start_r = 2'b00;
  logic [7:0] addr_r [2];
  logic [7:0] data_r [2];
  logic [1:0] pull_r = 2'b00;
  logic [7:0] slave_addr [2];
  logic [1:0] slave_present  = 2'b00;
  logic [1:0] slave_ack_data = 2'b00;
  logic [7:0] slave_out [2];

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  i2c_byte_writer_if u_if0 ();
  i2c_byte_writer_if u_if1 ();

  wire [1:0] w_scl_oe  = {u_if1.o_scl_oe,  u_if0.o_scl_oe};
  wire [1:0] w_sda_oe  = {u_if1.o_sda_oe,  u_if0.o_sda_oe};
  wire [1:0] w_busy    = {u_if1.o_busy,    u_if0.o_busy};
  wire [1:0] w_done    = {u_if1.o_done,    u_if0.o_done};
  wire [1:0] w_ack_err = {u_if1.o_ack_err, u_if0.o_ack_err};
  wire [1:0] w_sda_bus = ~(w_sda_oe | pull_r);

  assign u_if0.i_start  = start_r[0];
  assign u_if0.i_addr   = addr_r[0];
  assign u_if0.i_data   = data_r[0];
  assign u_if0.i_sda_in = w_sda_bus[0];
  assign u_if1.i_start  = start_r[1];
  assign u_if1.i_addr   = addr_r[1];
  assign u_if1.i_data   = data_r[1];
  assign u_if1.i_sda_in = w_sda_bus[1];

  i2c_byte_writer #(.CLK_DIV(DIV0)) u_dut0 (.i_clk(clk), .i_rst_n(rst_n_r[0]), .bus(u_if0));
  i2c_byte_writer #(.CLK_DIV(DIV1)) u_dut1 (.i_clk(clk), .i_rst_n(rst_n_r[1]), .bus(u_if1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ev(input int inst, input logic [3:0] kind, input logic [23:0] p);
    return {4'(inst), kind, p};
  endfunction

  // Scoreboard side of the monitor: every bus/host event is compared in order.
  task automatic observe(input int inst, input logic [3:0] kind, input logic [23:0] p);
    logic [31:0] act;
    act = ev(inst, kind, p);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got %h expected none at %0t", act, $time);
    end else begin
      check($sformatf("event_inst%0d", inst), act, exp_q.pop_front());
    end
  endtask

  // Expected events of one transaction; STOP payload 1 = only the STOP's own SCL rise.
  task automatic push_txn(input int inst, input logic [7:0] a, input logic [7:0] d,
                          input logic a_nack, input logic d_nack, input logic err,
                          input int cycles);
    exp_q.push_back(ev(inst, EV_START, 24'd0));
    exp_q.push_back(ev(inst, EV_BYTE, {15'd0, a_nack, a}));
    if (!a_nack) exp_q.push_back(ev(inst, EV_BYTE, {15'd0, d_nack, d}));
    exp_q.push_back(ev(inst, EV_STOP, 24'd1));
    exp_q.push_back(ev(inst, EV_DONE, {7'd0, err, 16'(cycles)}));
  endtask

  // Monitor: bus decoder, slave model and DONE timing for both instances.
  logic       prev_scl  [2] = '{1'b1, 1'b1};
  logic       prev_sda  [2] = '{1'b1, 1'b1};
  logic       prev_busy [2] = '{1'b0, 1'b0};
  int         bitcnt    [2] = '{0, 0};
  int         byte_idx  [2] = '{0, 0};
  int         cyc       [2] = '{0, 0};
  logic [7:0] shreg     [2];
  logic       addressed [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    logic scl, sda;
    for (int i = 0; i < 2; i++) begin
      scl = ~w_scl_oe[i];
      sda = w_sda_bus[i];
      cyc[i] = cyc[i] + 1;
      if (w_busy[i] && !prev_busy[i]) cyc[i] = 0;
      if (w_done[i]) observe(i, EV_DONE, {7'd0, w_ack_err[i], 16'(cyc[i])});
      if (scl && prev_scl[i] && (sda != prev_sda[i])) begin
        if (!sda) begin
          observe(i, EV_START, 24'd0);
          byte_idx[i]  = 0;
          addressed[i] = 1'b0;
        end else begin
          observe(i, EV_STOP, 24'(bitcnt[i]));
        end
        bitcnt[i] = 0;
        pull_r[i] = 1'b0;
      end else if (scl && !prev_scl[i]) begin
        if (bitcnt[i] < 8) begin
          shreg[i]  = {shreg[i][6:0], sda};
          bitcnt[i] = bitcnt[i] + 1;
        end else begin
          observe(i, EV_BYTE, {15'd0, sda, shreg[i]});
          bitcnt[i]   = 0;
          byte_idx[i] = byte_idx[i] + 1;
        end
      end else if (!scl && prev_scl[i]) begin
        if (bitcnt[i] == 8) begin
          if (byte_idx[i] == 0) begin
            addressed[i] = slave_present[i] && (shreg[i] == slave_addr[i]);
            pull_r[i]    = addressed[i];
          end else begin
            pull_r[i] = addressed[i] && slave_ack_data[i];
            if (pull_r[i]) slave_out[i] = shreg[i];
          end
        end else begin
          pull_r[i] = 1'b0;
        end
      end
      prev_scl[i]  = scl;
      prev_sda[i]  = sda;
      prev_busy[i] = w_busy[i];
    end
  end

  task automatic issue(input int inst, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    start_r[inst] = 1'b1;
    addr_r[inst]  = a;
    data_r[inst]  = d;
    @(negedge clk);
    start_r[inst] = 1'b0;
  endtask

  task automatic wait_done(input int inst, input int budget);
    int n;
    n = 0;
    while (!w_done[inst] && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("done_seen_inst%0d", inst), 32'(w_done[inst]), 32'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    addr_r = '{8'h00, 8'h00};
    data_r = '{8'h00, 8'h00};
    slave_addr = '{8'hAB, 8'h3C};
    slave_out  = '{8'h00, 8'h00};
    shreg      = '{8'h00, 8'h00};

    // Reset held for 3 cycles with a pending request.
    start_r = 2'b11;
    addr_r  = '{8'hAB, 8'hAB};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs", {w_scl_oe, w_sda_oe, w_busy, w_done, w_ack_err}, 32'd0);
    end
    start_r = 2'b00;
    rst_n_r = 2'b11;
    repeat (6) @(negedge clk);
    check("idle_after_reset", {w_scl_oe, w_sda_oe, w_busy}, 32'd0);

    // Nominal write, CLK_DIV=4.
    slave_present  = 2'b11;
    slave_ack_data = 2'b11;
    push_txn(0, 8'hAB, 8'h5A, 1'b0, 1'b0, 1'b0, 312);
    issue(0, 8'hAB, 8'h5A);
    wait_done(0, 600);
    check("nominal_ack_err", 32'(w_ack_err[0]), 32'd0);
    check("nominal_busy_low", 32'(w_busy[0]), 32'd0);
    check("slave_out_5a", 32'(slave_out[0]), 32'h5A);

    // Address NACK: nobody at 0x12.
    push_txn(0, 8'h12, 8'h77, 1'b1, 1'b0, 1'b1, 168);
    issue(0, 8'h12, 8'h77);
    wait_done(0, 600);
    check("addr_nack_err", 32'(w_ack_err[0]), 32'd1);

    // Data NACK, then a good transaction clears ACK_ERR on accept.
    slave_ack_data[0] = 1'b0;
    push_txn(0, 8'hAB, 8'h3C, 1'b0, 1'b1, 1'b1, 312);
    issue(0, 8'hAB, 8'h3C);
    wait_done(0, 600);
    check("data_nack_err", 32'(w_ack_err[0]), 32'd1);
    @(negedge clk);
    slave_ack_data[0] = 1'b1;
    push_txn(0, 8'hAB, 8'h81, 1'b0, 1'b0, 1'b0, 312);
    start_r[0] = 1'b1;
    addr_r[0]  = 8'hAB;
    data_r[0]  = 8'h81;
    @(posedge clk);
    #1;
    check("ack_err_cleared_on_accept", {w_ack_err[0], w_busy[0]}, 32'b01);
    @(negedge clk);
    start_r[0] = 1'b0;
    wait_done(0, 600);
    check("slave_out_81", 32'(slave_out[0]), 32'h81);

    // Request handling, CLK_DIV=5: START while busy is ignored.
    push_txn(1, 8'h3C, 8'h96, 1'b0, 1'b0, 1'b0, 390);
    issue(1, 8'h3C, 8'h96);
    repeat (50) @(negedge clk);
    start_r[1] = 1'b1;
    addr_r[1]  = 8'hFF;
    data_r[1]  = 8'h00;
    @(negedge clk);
    start_r[1] = 1'b0;
    check("busy_during_ignored_start", 32'(w_busy[1]), 32'd1);
    wait_done(1, 700);
    check("slave_out_96", 32'(slave_out[1]), 32'h96);

    // START in the DONE cycle starts the next transaction immediately.
    push_txn(1, 8'h3C, 8'h69, 1'b0, 1'b0, 1'b0, 390);
    start_r[1] = 1'b1;
    addr_r[1]  = 8'h3C;
    data_r[1]  = 8'h69;
    @(negedge clk);
    start_r[1] = 1'b0;
    check("back_to_back_busy", {w_busy[1], w_sda_oe[1]}, 32'b11);
    wait_done(1, 700);
    check("slave_out_69", 32'(slave_out[1]), 32'h69);

    // Reset during DATA bit 3 (Q1, SCL high, SDA held low for a 0 bit).
    exp_q.push_back(ev(0, EV_START, 24'd0));
    exp_q.push_back(ev(0, EV_BYTE, {15'd0, 1'b0, 8'hAB}));
    exp_q.push_back(ev(0, EV_STOP, 24'd5));
    issue(0, 8'hAB, 8'hC3);
    repeat (220) @(negedge clk);
    check("before_reset_bit3", {w_scl_oe[0], w_sda_oe[0], w_busy[0]}, 32'b011);
    rst_n_r[0] = 1'b0;
    @(negedge clk);
    check("mid_reset_outputs", {w_scl_oe[0], w_sda_oe[0], w_busy[0], w_done[0]}, 32'd0);
    rst_n_r[0] = 1'b1;
    repeat (4) @(negedge clk);
    push_txn(0, 8'hAB, 8'h5A, 1'b0, 1'b0, 1'b0, 312);
    issue(0, 8'hAB, 8'h5A);
    wait_done(0, 600);
    check("slave_out_after_reset", 32'(slave_out[0]), 32'h5A);

    repeat (10) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
